// File: rtl/mat_store.sv
// Matrix writer: lays down a header word for rows, a header word for cols, then the
// row-major 32-bit elements, through a single vmem write port fed by a valid/ready stream.
module mat_store #(
  parameter int MAX_DIM = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] rows,
  input  logic [31:0] cols,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  // Handshake: an element transfers on a rising edge where in_valid & in_ready are both
  // high; in_ready depends only on state, never on in_valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR_R = 3'd1,
    S_HDR_C = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam int IDX_W = 2 * CNT_W;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [CNT_W-1:0] cols_q, cols_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] c_q, c_d;

  logic             dims_ok;
  logic [IDX_W-1:0] elem_idx;
  logic [31:0]      elem_addr;
  logic             last_col;
  logic             last_row;

  assign dims_ok = (rows >= 32'd1) && (rows <= 32'(MAX_DIM)) &&
                   (cols >= 32'd1) && (cols <= 32'(MAX_DIM));

  // Element offset in words; all address arithmetic wraps modulo 2^32.
  assign elem_idx  = IDX_W'(r_q) * IDX_W'(cols_q) + IDX_W'(c_q);
  assign elem_addr = base_q + 32'd8 + (32'(elem_idx) << 2);

  assign last_col = (c_q == cols_q - ONE);
  assign last_row = (r_q == rows_q - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    r_d      = r_q;
    c_d      = c_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            base_d  = base_addr;
            rows_d  = rows[CNT_W-1:0];
            cols_d  = cols[CNT_W-1:0];
            r_d     = '0;
            c_d     = '0;
            state_d = S_HDR_R;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_HDR_R: begin
        mem_we   = 1'b1;
        mem_addr = base_q;
        mem_wd   = 32'(rows_q);
        state_d  = S_HDR_C;
      end
      S_HDR_C: begin
        mem_we   = 1'b1;
        mem_addr = base_q + 32'd4;
        mem_wd   = 32'(cols_q);
        state_d  = S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        mem_addr = elem_addr;
        mem_wd   = in_data;
        if (in_valid) begin
          if (last_col) begin
            c_d = '0;
            r_d = r_q + ONE;
            if (last_row) state_d = S_DONE;
          end else begin
            c_d = c_q + ONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mat_store.sv
// Bench for mat_store: directed stores push expected writes/pulses into a queue and a
// negedge monitor pops and compares every write, done and err the DUT presents.
module tb_mat_store;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] rows;
  logic [31:0] cols;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  logic [65:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mat_store #(.MAX_DIM(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .rows(rows), .cols(cols), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " mem_we"},   32'(mem_we),   32'd0);
    chk({tag, " mem_addr"}, mem_addr,      32'd0);
    chk({tag, " mem_wd"},   mem_wd,        32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " done"},     32'(done),     32'd0);
    chk({tag, " err"},      32'(err),      32'd0);
  endtask

  // monitor / scoreboard
  task automatic pop_cmp(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
    logic [65:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind=%0d addr=%h data=%h, expected nothing", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, a, d}) begin
        errors++;
        $display("FAIL scoreboard: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                 kind, a, d, e[65:64], e[63:32], e[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) pop_cmp(K_WR, mem_addr, mem_wd);
      if (done)   pop_cmp(K_DONE, 32'd0, 32'd0);
      if (err)    pop_cmp(K_ERR, 32'd0, 32'd0);
    end
  end

  // drivers
  // vpat 0: in_valid always high; 1: in_valid 1,0,0,1,0,0...
  // inj: cycle at which a stray start (rows=9) is pulsed; 0 = none
  // abort_k: pull reset low once this many elements have been accepted; 0 = none
  task automatic run_store(input logic [31:0] base, input int nr, input int nc, input int vpat,
                           input logic [31:0] off, input int inj, input int abort_k);
    int n, k, cyc, done_cyc;
    bit done_seen, aborted;
    n = nr * nc;
    exp_q.push_back({K_WR, base, 32'(nr)});
    exp_q.push_back({K_WR, base + 32'd4, 32'(nc)});
    for (int i = 0; i < n; i++) begin
      if (abort_k == 0 || i < abort_k)
        exp_q.push_back({K_WR, base + 32'd8 + 32'(4 * i), off + 32'(i + 1)});
    end
    if (abort_k == 0) exp_q.push_back({K_DONE, 64'd0});

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; rows = 32'(nr); cols = 32'(nc);
    k = 0; cyc = 0; done_cyc = 0; done_seen = 0; aborted = 0;
    while (!done_seen && !aborted && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = (inj != 0 && cyc == inj);
      if (start) begin
        base_addr = 32'h0000_0F00; rows = 32'd9; cols = 32'd9;
      end
      in_valid = (vpat == 0) ? 1'b1 : (cyc % 3 == 1);
      in_data  = off + 32'(k + 1);
      if (abort_k != 0 && k == abort_k) begin
        #1 reset = 1'b0;
        #1 chk_outputs_zero("async reset");
        chk("async reset state", 32'(dbg_state), 32'd0);
        aborted = 1;
      end else begin
        @(negedge clk);
        if (in_valid && in_ready) k++;
        if (done) begin
          done_seen = 1;
          done_cyc = cyc;
        end
      end
    end
    start = 1'b0; in_valid = 1'b0;
    if (abort_k == 0) begin
      chk("done seen", 32'(done_seen), 32'd1);
      chk("elements accepted", 32'(k), 32'(n));
      if (vpat == 0) chk("done latency", 32'(done_cyc), 32'(n + 3));
      @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle mem_we", 32'(mem_we), 32'd0);
    end
    chk("queue drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_err(input logic [31:0] nr, input logic [31:0] nc);
    @(posedge clk); #1;
    start = 1'b1; rows = nr; cols = nc; base_addr = 32'h0000_0500;
    exp_q.push_back({K_ERR, 64'd0});
    @(negedge clk);
    chk("err pre busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err cycle busy", 32'(busy), 32'd1);
    chk("err cycle in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("err after busy", 32'(busy), 32'd0);
    chk("err queue drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = 32'h1234_5678; rows = 32'd3; cols = 32'd3;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    #12;
    chk_outputs_zero("reset");
    chk("reset state", 32'(dbg_state), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // 2x3 at 0x100, data 1..6, in_valid held high
    run_store(32'h0000_0100, 2, 3, 0, 32'd0, 0, 0);
    // same store under backpressure
    run_store(32'h0000_0100, 2, 3, 1, 32'd0, 0, 0);
    // illegal dims
    run_err(32'd0, 32'd4);
    run_err(32'd17, 32'd1);
    run_err(32'd3, 32'd0);
    // stray start during DATA of a 1x4
    run_store(32'h0000_0200, 1, 4, 0, 32'hA000_0000, 5, 0);
    // reset after the 3rd element of a 2x2, then a 1x1 at 0x40
    run_store(32'h0000_0300, 2, 2, 0, 32'h0000_0010, 0, 3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_store(32'h0000_0040, 1, 1, 0, 32'h1234_5677, 0, 0);
    // address wrap past 0xFFFFFFFF
    run_store(32'hFFFF_FFF8, 1, 2, 0, 32'h3F80_0000, 0, 0);
    // largest legal dims
    run_store(32'h0000_1000, 16, 16, 0, 32'd0, 0, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
